exe_stage_mc: RTL and testbench

Parametrised execute stage with valid/ready handshakes, an N-source forwarding mux and an iterative multiply/divide unit owning HI/LO. Sits between decode/issue and MEM. Single-cycle ALU ops pass in one cycle. MULT/MULTU/DIV/DIVU occupy the stage for XLEN cycles and back-pressure issue. Supersedes the fixed 32-bit, no-stall execute stage.

---
 rtl/exe_pkg.sv | 47 ++++
 rtl/exe_alu.sv | 35 +++
 rtl/exe_muldiv_seq.sv | 101 ++++++++++
 rtl/exe_stage_mc.sv | 169 ++++++++++++++++
 tb/tb_exe_stage_mc.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the multi-cycle execute stage: op codes, FSM states and sideband bundle.
package exe_pkg;

  localparam int unsigned XlenDefault = 32;

  localparam logic [5:0] OpSll   = 6'h00;
  localparam logic [5:0] OpSrl   = 6'h02;
  localparam logic [5:0] OpSra   = 6'h03;
  localparam logic [5:0] OpSllv  = 6'h04;
  localparam logic [5:0] OpSrlv  = 6'h06;
  localparam logic [5:0] OpSrav  = 6'h07;
  localparam logic [5:0] OpMfhi  = 6'h10;
  localparam logic [5:0] OpMthi  = 6'h11;
  localparam logic [5:0] OpMflo  = 6'h12;
  localparam logic [5:0] OpMtlo  = 6'h13;
  localparam logic [5:0] OpMult  = 6'h18;
  localparam logic [5:0] OpMultu = 6'h19;
  localparam logic [5:0] OpDiv   = 6'h1A;
  localparam logic [5:0] OpDivu  = 6'h1B;
  localparam logic [5:0] OpAdd   = 6'h20;
  localparam logic [5:0] OpAddu  = 6'h21;
  localparam logic [5:0] OpSub   = 6'h22;
  localparam logic [5:0] OpSubu  = 6'h23;
  localparam logic [5:0] OpAnd   = 6'h24;
  localparam logic [5:0] OpOr    = 6'h25;
  localparam logic [5:0] OpXor   = 6'h26;
  localparam logic [5:0] OpNor   = 6'h27;
  localparam logic [5:0] OpSlt   = 6'h2A;
  localparam logic [5:0] OpSltu  = 6'h2B;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} exe_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  wreg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  ctrl;
  } exe_side_t;

  function automatic logic is_muldiv(input logic [5:0] c);
    return c inside {OpMult, OpMultu, OpDiv, OpDivu};
  endfunction

endpackage

// File: rtl/exe_alu.sv
// Single-cycle integer ALU for the simple (non HI/LO) operations.
module exe_alu
  import exe_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      shamt,
  input  logic [5:0]      ctrl,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = '0;
    case (ctrl)
      OpAdd, OpAddu: result = a + b;
      OpSub, OpSubu: result = a - b;
      OpAnd:         result = a & b;
      OpOr:          result = a | b;
      OpXor:         result = a ^ b;
      OpNor:         result = ~(a | b);
      OpSlt:         result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSltu:        result = {{(XLEN-1){1'b0}}, (a < b)};
      OpSll:         result = b << shamt;
      OpSrl:         result = b >> shamt;
      OpSra:         result = $unsigned($signed(b) >>> shamt);
      OpSllv:        result = b << a[4:0];
      OpSrlv:        result = b >> a[4:0];
      OpSrav:        result = $unsigned($signed(b) >>> a[4:0]);
      default:       result = '0;
    endcase
  end

endmodule

// File: rtl/exe_muldiv_seq.sv
// Iterative multiply (shift-add) / divide (restoring), one bit per cycle over XLEN cycles.
module exe_muldiv_seq
  import exe_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            kill,
  input  logic            start,
  input  logic [1:0]      op,      // [1] divide, [0] unsigned
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  logic              busy_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   dvs_q, dvd_q;
  logic              is_div_q, neg_q, rneg_q, dz_q;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     sum, trial;

  assign a_neg = ~op[0] & a[XLEN-1];
  assign b_neg = ~op[0] & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(XLEN - 1));

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? dvs_q : '0)};
    trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, dvs_q};
    if (!is_div_q) begin
      acc_d = {sum, acc_q[XLEN-1:1]};
    end else if (!trial[XLEN]) begin
      acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_d = {acc_q[2*XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    hi = acc_d[2*XLEN-1:XLEN];
    lo = acc_d[XLEN-1:0];
    if (!is_div_q) begin
      if (neg_q) {hi, lo} = -acc_d;
    end else if (dz_q) begin
      hi = dvd_q;
      lo = '1;
    end else begin
      if (neg_q)  lo = -acc_d[XLEN-1:0];
      if (rneg_q) hi = -acc_d[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      dvs_q    <= '0;
      dvd_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else if (kill || done) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      is_div_q <= op[1];
      neg_q    <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      dz_q     <= (b == '0);
      dvd_q    <= a;
      if (op[1]) begin
        acc_q <= {{XLEN{1'b0}}, a_mag};
        dvs_q <= b_mag;
      end else begin
        acc_q <= {{XLEN{1'b0}}, b_mag};
        dvs_q <= a_mag;
      end
    end
  end

endmodule

// File: rtl/exe_stage_mc.sv
// Execute stage: forwarding mux, single-cycle ALU, iterative MUL/DIV owning HI/LO, and a
// valid/ready output register toward MEM.
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int unsigned XLEN    = XlenDefault,
  parameter int unsigned FWD_SRC = 2,
  localparam int unsigned SW     = $clog2(FWD_SRC + 1)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    Flush,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic [31:0]             Instr_IN,
  input  logic [31:0]             Instr_PC_IN,
  input  logic [XLEN-1:0]         OperandA_IN,
  input  logic [XLEN-1:0]         OperandB_IN,
  input  logic [XLEN-1:0]         MemWriteData_IN,
  input  logic [SW-1:0]           RegA_Select,
  input  logic [SW-1:0]           RegB_Select,
  input  logic [FWD_SRC*XLEN-1:0] Fwd_Data,
  input  logic [5:0]              ALU_Control_IN,
  input  logic [4:0]              ShiftAmount_IN,
  input  logic [4:0]              WriteRegister_IN,
  input  logic                    RegWrite_IN,
  input  logic                    MemRead_IN,
  input  logic                    MemWrite_IN,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic [31:0]             Instr_OUT,
  output logic [31:0]             Instr_PC_OUT,
  output logic [XLEN-1:0]         ALU_result_OUT,
  output logic [XLEN-1:0]         MemWriteData_OUT,
  output logic [4:0]              WriteRegister_OUT,
  output logic                    RegWrite_OUT,
  output logic                    MemRead_OUT,
  output logic                    MemWrite_OUT,
  output logic [5:0]              ALU_Control_OUT,
  output logic [XLEN-1:0]         HI_OUT,
  output logic [XLEN-1:0]         LO_OUT,
  output logic                    Busy
);

  exe_state_e      state_q, state_d;
  exe_side_t       side_in, side_q, out_side_q;
  logic [XLEN-1:0] op_a, op_b, alu_res, simple_res;
  logic [XLEN-1:0] hi_q, lo_q, md_hi, md_lo, mwd_q;
  logic            accept, is_md, md_done, md_busy;

  always_comb begin
    op_a = OperandA_IN;
    op_b = OperandB_IN;
    for (int unsigned k = 1; k <= FWD_SRC; k++) begin
      if (RegA_Select == SW'(k)) op_a = Fwd_Data[(k-1)*XLEN +: XLEN];
      if (RegB_Select == SW'(k)) op_b = Fwd_Data[(k-1)*XLEN +: XLEN];
    end
  end

  assign In_Ready = (state_q == StIdle) && (!Out_Valid || Out_Ready) && !Flush;
  assign accept   = In_Valid && In_Ready;
  assign is_md    = is_muldiv(ALU_Control_IN);
  assign Busy     = (state_q != StIdle);

  assign side_in = '{instr: Instr_IN, pc: Instr_PC_IN, wreg: WriteRegister_IN,
                     reg_write: RegWrite_IN, mem_read: MemRead_IN, mem_write: MemWrite_IN,
                     ctrl: ALU_Control_IN};

  exe_alu #(.XLEN(XLEN)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .shamt  (ShiftAmount_IN),
    .ctrl   (ALU_Control_IN),
    .result (alu_res)
  );

  exe_muldiv_seq #(.XLEN(XLEN)) u_muldiv (
    .clk   (CLK),
    .reset (RESET),
    .kill  (Flush),
    .start (accept && is_md),
    .op    (ALU_Control_IN[1:0]),
    .a     (op_a),
    .b     (op_b),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:       if (accept && is_md) state_d = ALU_Control_IN[1] ? StDiv : StMul;
      StMul, StDiv: if (md_done) state_d = StIdle;
      default:      state_d = StIdle;
    endcase
    if (Flush) state_d = StIdle;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    simple_res = alu_res;
    case (ALU_Control_IN)
      OpMfhi:         simple_res = hi_q;
      OpMflo:         simple_res = lo_q;
      OpMthi, OpMtlo: simple_res = op_a;
      default:        simple_res = alu_res;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      Out_Valid        <= 1'b0;
      ALU_result_OUT   <= '0;
      MemWriteData_OUT <= '0;
      out_side_q       <= '0;
      side_q           <= '0;
      mwd_q            <= '0;
      hi_q             <= '0;
      lo_q             <= '0;
    end else if (Flush) begin
      Out_Valid <= 1'b0;
    end else if (md_done) begin
      hi_q             <= md_hi;
      lo_q             <= md_lo;
      Out_Valid        <= 1'b1;
      ALU_result_OUT   <= md_lo;
      MemWriteData_OUT <= mwd_q;
      out_side_q       <= side_q;
    end else if (accept) begin
      if (is_md) begin
        // Previous result was consumed this cycle; hold sideband until completion.
        Out_Valid <= 1'b0;
        side_q    <= side_in;
        mwd_q     <= MemWriteData_IN;
      end else begin
        Out_Valid        <= 1'b1;
        ALU_result_OUT   <= simple_res;
        MemWriteData_OUT <= MemWriteData_IN;
        out_side_q       <= side_in;
        if (ALU_Control_IN == OpMthi) hi_q <= op_a;
        if (ALU_Control_IN == OpMtlo) lo_q <= op_a;
      end
    end else if (Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

  assign Instr_OUT         = out_side_q.instr;
  assign Instr_PC_OUT      = out_side_q.pc;
  assign WriteRegister_OUT = out_side_q.wreg;
  assign RegWrite_OUT      = out_side_q.reg_write;
  assign MemRead_OUT       = out_side_q.mem_read;
  assign MemWrite_OUT      = out_side_q.mem_write;
  assign ALU_Control_OUT   = out_side_q.ctrl;
  assign HI_OUT            = hi_q;
  assign LO_OUT            = lo_q;

  // Issue gating guarantees the output register is free whenever a multi-cycle op completes.
  assert property (@(posedge CLK) disable iff (RESET)
                   (md_done && !Flush) |-> (!Out_Valid || Out_Ready));
  assert property (@(posedge CLK) disable iff (RESET) md_busy == (state_q != StIdle));

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc: one XLEN=32 instance and one XLEN=16 instance.
module tb_exe_stage_mc;
  import exe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, out_ready, out_valid, busy;
  logic [31:0] instr, pc, instr_o, pc_o;
  logic [31:0] op_a, op_b, mwd, res, mwd_o, hi, lo;
  logic [1:0]  sel_a, sel_b, sel16;
  logic [63:0] fwd;
  logic [5:0]  ctrl, ctrl_o;
  logic [4:0]  shamt, wreg, wreg_o;
  logic        rw, mr, mw, rw_o, mr_o, mw_o;

  logic        in_valid16, flush16, in_ready16, out_valid16, busy16;
  logic [15:0] op_a16, op_b16, mwd16, res16, mwd16_o, hi16, lo16;
  logic [31:0] fwd16, instr16_o, pc16_o;
  logic [5:0]  ctrl16, ctrl16_o;
  logic [4:0]  wreg16_o;
  logic        rw16_o, mr16_o, mw16_o;

  exe_stage_mc #(.XLEN(32), .FWD_SRC(2)) dut (
    .CLK(clk), .RESET(rst), .Flush(flush), .In_Valid(in_valid), .In_Ready(in_ready),
    .Instr_IN(instr), .Instr_PC_IN(pc), .OperandA_IN(op_a), .OperandB_IN(op_b),
    .MemWriteData_IN(mwd), .RegA_Select(sel_a), .RegB_Select(sel_b), .Fwd_Data(fwd),
    .ALU_Control_IN(ctrl), .ShiftAmount_IN(shamt), .WriteRegister_IN(wreg),
    .RegWrite_IN(rw), .MemRead_IN(mr), .MemWrite_IN(mw), .Out_Valid(out_valid),
    .Out_Ready(out_ready), .Instr_OUT(instr_o), .Instr_PC_OUT(pc_o), .ALU_result_OUT(res),
    .MemWriteData_OUT(mwd_o), .WriteRegister_OUT(wreg_o), .RegWrite_OUT(rw_o),
    .MemRead_OUT(mr_o), .MemWrite_OUT(mw_o), .ALU_Control_OUT(ctrl_o), .HI_OUT(hi),
    .LO_OUT(lo), .Busy(busy)
  );

  exe_stage_mc #(.XLEN(16), .FWD_SRC(2)) dut16 (
    .CLK(clk), .RESET(rst), .Flush(flush16), .In_Valid(in_valid16), .In_Ready(in_ready16),
    .Instr_IN(instr), .Instr_PC_IN(pc), .OperandA_IN(op_a16), .OperandB_IN(op_b16),
    .MemWriteData_IN(mwd16), .RegA_Select(sel16), .RegB_Select(sel16), .Fwd_Data(fwd16),
    .ALU_Control_IN(ctrl16), .ShiftAmount_IN(shamt), .WriteRegister_IN(wreg),
    .RegWrite_IN(rw), .MemRead_IN(mr), .MemWrite_IN(mw), .Out_Valid(out_valid16),
    .Out_Ready(out_ready), .Instr_OUT(instr16_o), .Instr_PC_OUT(pc16_o), .ALU_result_OUT(res16),
    .MemWriteData_OUT(mwd16_o), .WriteRegister_OUT(wreg16_o), .RegWrite_OUT(rw16_o),
    .MemRead_OUT(mr16_o), .MemWrite_OUT(mw16_o), .ALU_Control_OUT(ctrl16_o), .HI_OUT(hi16),
    .LO_OUT(lo16), .Busy(busy16)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic issue16(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b);
    ctrl16 = c; op_a16 = a; op_b16 = b; in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
  endtask

  task automatic wait_out16(output int n);
    n = 0;
    while (!out_valid16 && n < 200) begin tick(); n++; end
  endtask

  // Multi-cycle op on the 32-bit instance, then compare cycle count and HI/LO.
  task automatic run_md(input string tag, input logic [5:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    issue(c, a, b);
    wait_out(n);
    check({tag, "_cycles"}, n, 32);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_res"}, res, exp_lo);
  endtask

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'hDEAD_BEEF; pc = 32'h0000_0400; op_a = '0; op_b = '0; mwd = 32'h55;
    sel_a = '0; sel_b = '0; sel16 = '0; fwd = '0; ctrl = OpAdd; shamt = '0; wreg = 5'd7;
    rw = 1'b1; mr = 1'b0; mw = 1'b0;
    in_valid16 = 1'b0; flush16 = 1'b0; op_a16 = '0; op_b16 = '0; mwd16 = '0; fwd16 = '0;
    ctrl16 = OpAdd;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_res", res, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);

    // Forwarding selects
    fwd = {32'h10, 32'h77};
    sel_a = 2'd2;
    issue(OpAdd, 32'h999, 32'h5);
    check("fwd2_valid", out_valid, 1);
    check("fwd2_res", res, 32'h15);
    check("fwd2_wreg", wreg_o, 7);
    check("fwd2_pc", pc_o, 32'h400);
    sel_a = 2'd1;
    issue(OpAdd, 32'h999, 32'h5);
    check("fwd1_res", res, 32'h7C);
    sel_a = 2'd3;
    issue(OpAdd, 32'h999, 32'h5);
    check("fwd_oob_res", res, 32'h99E);
    sel_a = 2'd0; sel_b = 2'd1;
    issue(OpSub, 32'h100, 32'h0);
    check("fwdb_res", res, 32'h89);
    sel_b = 2'd0;

    issue(OpMthi, 32'h1234, 32'h0);
    check("mthi_res", res, 32'h1234);
    check("mthi_hi", hi, 32'h1234);
    issue(OpMtlo, 32'h5678, 32'h0);
    check("mtlo_lo", lo, 32'h5678);

    // MULT -3*7 with MFHI queued behind it
    issue(OpMult, 32'hFFFF_FFFD, 32'd7);
    check("mult_busy", busy, 1);
    check("mult_valid0", out_valid, 0);
    ctrl = OpMfhi; in_valid = 1'b1;
    #1;
    check("mult_inready", in_ready, 0);
    wait_out(n);
    check("mult_cycles", n, 32);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    check("mult_res", res, 32'hFFFF_FFEB);
    tick();
    in_valid = 1'b0;
    check("mfhi_res", res, 32'hFFFF_FFFF);
    check("mfhi_ctrl", ctrl_o, OpMfhi);

    run_md("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu_zero", OpDivu, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_md("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_md("divu", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14);
    run_md("multu", OpMultu, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);

    // Back-pressure
    tick();
    out_ready = 1'b0; wreg = 5'd9;
    issue(OpAdd, 32'd3, 32'd4);
    check("bp_valid", out_valid, 1);
    check("bp_res", res, 32'd7);
    ctrl = OpSub; op_a = 32'd10; op_b = 32'd4; wreg = 5'd3; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_res", res, 32'd7);
      check("bp_hold_wreg", wreg_o, 9);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_next_res", res, 32'd6);
    check("bp_next_wreg", wreg_o, 3);

    // Flush mid-DIVU
    issue(OpMthi, 32'h1234, 32'h0);
    issue(OpMtlo, 32'h5678, 32'h0);
    issue(OpDivu, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    #1;
    check("flush_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_busy", busy, 0);
    check("flush_hi", hi, 32'h1234);
    check("flush_lo", lo, 32'h5678);
    for (int i = 0; i < 40; i++) tick();
    check("flush_quiet", out_valid, 0);
    issue(OpAdd, 32'd1, 32'd2);
    check("flush_add_valid", out_valid, 1);
    check("flush_add_res", res, 32'd3);

    // XLEN=16 instance
    issue16(OpMthi, 16'hAAAA, 16'h0);
    issue16(OpMtlo, 16'h5555, 16'h0);
    check("x16_hi", hi16, 16'hAAAA);
    check("x16_lo", lo16, 16'h5555);
    issue16(OpMultu, 16'h00FF, 16'h0101);
    wait_out16(n);
    check("x16_multu_cycles", n, 16);
    check("x16_multu_hi", hi16, 16'h0000);
    check("x16_multu_lo", lo16, 16'hFFFF);
    issue16(OpMult, 16'hFFFD, 16'd7);
    wait_out16(n);
    check("x16_mult_hi", hi16, 16'hFFFF);
    check("x16_mult_lo", lo16, 16'hFFEB);
    issue16(OpDivu, 16'd1000, 16'd7);
    for (int i = 0; i < 9; i++) tick();
    flush16 = 1'b1;
    tick();
    flush16 = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("x16_flush_valid", out_valid16, 0);
    check("x16_flush_hi", hi16, 16'hFFFF);
    check("x16_flush_lo", lo16, 16'hFFEB);
    issue16(OpAdd, 16'd1, 16'd2);
    check("x16_add_valid", out_valid16, 1);
    check("x16_add_res", res16, 16'd3);

    // Reset mid-MULT
    issue(OpMult, 32'd5, 32'd6);
    tick(); tick(); tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst2_valid", out_valid, 0);
    check("rst2_res", res, 0);
    check("rst2_wreg", wreg_o, 0);
    check("rst2_hi", hi, 0);
    check("rst2_lo", lo, 0);
    check("rst2_busy", busy, 0);
    check("rst2_ready", in_ready, 1);
    for (int i = 0; i < 40; i++) tick();
    check("rst2_quiet", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
